// File: rtl/time_params_pkg.sv
// ----------------------------------------------------------------------------
// time_params_pkg
// Shared definitions for the alarm-controller timing-parameter bank:
//   - param_sel_e : which of the four timing registers a write targets
//   - TIME_W      : default bit width of a time value (seconds)
//   - TP_DEF_*    : power-on values of the four delays
//   - sel_decode  : select + enable -> one-hot register write enables
// ----------------------------------------------------------------------------
package time_params_pkg;

    localparam int TIME_W     = 4;
    localparam int NUM_PARAMS = 4;

    // Power-on delays, in seconds
    localparam int TP_DEF_ARM       = 6;
    localparam int TP_DEF_DRIVER    = 8;
    localparam int TP_DEF_PASSENGER = 15;
    localparam int TP_DEF_ALARM     = 10;

    typedef enum logic [1:0] {
        SEL_ARM       = 2'd0,
        SEL_DRIVER    = 2'd1,
        SEL_PASSENGER = 2'd2,
        SEL_ALARM     = 2'd3
    } param_sel_e;

    // One-hot write enable for the selected register. When en is low no
    // register is enabled, so the select value does not matter.
    function automatic logic [NUM_PARAMS-1:0] sel_decode(input param_sel_e sel,
                                                         input logic       en);
        logic [NUM_PARAMS-1:0] onehot;
        onehot = '0;
        if (en) begin
            onehot = NUM_PARAMS'(1) << sel;
        end
        return onehot;
    endfunction

endpackage

// File: rtl/time_parameters_if.sv
// ----------------------------------------------------------------------------
// time_parameters_if
// Reprogramming port of the timing-parameter bank.
//   param_select : target register (see param_sel_e)
//   time_value   : new value for the selected register, WIDTH bits
//   reprogram    : level-sensitive write strobe, sampled on rising clk
// Modports:
//   master : drives a write (controller / testbench side)
//   slave  : receives a write (time_parameters side)
// ----------------------------------------------------------------------------
interface time_parameters_if #(
    parameter int WIDTH = time_params_pkg::TIME_W
);
    import time_params_pkg::*;

    param_sel_e       param_select;
    logic [WIDTH-1:0] time_value;
    logic             reprogram;

    modport master (
        output param_select,
        output time_value,
        output reprogram
    );

    modport slave (
        input param_select,
        input time_value,
        input reprogram
    );

endinterface

// File: rtl/tp_reg.sv
// ----------------------------------------------------------------------------
// tp_reg
// One timing-parameter register: WIDTH bits, asynchronous active-low reset
// to a parameterised default, loaded from d when we is high on a rising clk.
// Ports:
//   clk : clock
//   rst : asynchronous reset, active low
//   we  : write enable
//   d   : value to load
//   q   : register contents (driven directly by the flop)
// ----------------------------------------------------------------------------
module tp_reg #(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] DEFAULT = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_reg <= DEFAULT;
        end else if (we) begin
            q_reg <= d;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/time_parameters.sv
// ----------------------------------------------------------------------------
// time_parameters
// Programmable timing-parameter register bank for the anti-theft alarm
// controller. Holds the arm delay, driver-door delay, passenger-door delay and
// siren-on duration (seconds). Any one of them can be rewritten at run time
// through the cfg port; every output comes straight from a register.
//
// Ports:
//   clk               : clock, all writes on its rising edge
//   rst               : asynchronous reset, active low; loads the DEF_* values
//   cfg               : time_parameters_if.slave (param_select, time_value,
//                       reprogram)
//   T_ARM_DELAY       : arm delay
//   T_DRIVER_DELAY    : driver-door entry delay
//   T_PASSENGER_DELAY : passenger-door entry delay
//   T_ALARM_ON        : siren-on duration
//
// Build option:
//   TP_ZERO_REJECT_EN : when defined, a write carrying time_value == 0 is
//                       dropped so no delay can be programmed to zero length.
// ----------------------------------------------------------------------------
module time_parameters
    import time_params_pkg::*;
#(
    parameter int               WIDTH         = TIME_W,
    parameter logic [WIDTH-1:0] DEF_ARM       = WIDTH'(TP_DEF_ARM),
    parameter logic [WIDTH-1:0] DEF_DRIVER    = WIDTH'(TP_DEF_DRIVER),
    parameter logic [WIDTH-1:0] DEF_PASSENGER = WIDTH'(TP_DEF_PASSENGER),
    parameter logic [WIDTH-1:0] DEF_ALARM     = WIDTH'(TP_DEF_ALARM)
) (
    input  logic             clk,
    input  logic             rst,
    time_parameters_if.slave cfg,
    output logic [WIDTH-1:0] T_ARM_DELAY,
    output logic [WIDTH-1:0] T_DRIVER_DELAY,
    output logic [WIDTH-1:0] T_PASSENGER_DELAY,
    output logic [WIDTH-1:0] T_ALARM_ON
);

    // Defaults packed in select order so register gi picks slice gi.
    localparam logic [NUM_PARAMS*WIDTH-1:0] DEF_VEC =
        {DEF_ALARM, DEF_PASSENGER, DEF_DRIVER, DEF_ARM};

    logic                  write_ok;
    logic [NUM_PARAMS-1:0] reg_we;
    logic [WIDTH-1:0]      reg_q [NUM_PARAMS];

    // Qualified write strobe. The zero filter sits here, ahead of the decode,
    // so a rejected write leaves every register untouched.
`ifdef TP_ZERO_REJECT_EN
    assign write_ok = cfg.reprogram && (cfg.time_value != '0);
`else
    assign write_ok = cfg.reprogram;
`endif

    assign reg_we = sel_decode(cfg.param_select, write_ok);

    generate
        for (genvar gi = 0; gi < NUM_PARAMS; gi++) begin : g_param
            tp_reg #(
                .WIDTH   (WIDTH),
                .DEFAULT (DEF_VEC[gi*WIDTH +: WIDTH])
            ) u_reg (
                .clk (clk),
                .rst (rst),
                .we  (reg_we[gi]),
                .d   (cfg.time_value),
                .q   (reg_q[gi])
            );
        end
    endgenerate

    assign T_ARM_DELAY       = reg_q[int'(SEL_ARM)];
    assign T_DRIVER_DELAY    = reg_q[int'(SEL_DRIVER)];
    assign T_PASSENGER_DELAY = reg_q[int'(SEL_PASSENGER)];
    assign T_ALARM_ON        = reg_q[int'(SEL_ALARM)];

endmodule

// File: tb/tb_time_parameters.sv
// ----------------------------------------------------------------------------
// tb_time_parameters
// Directed stimulus drives the reprogramming port and pushes the expected
// register snapshot into a queue; an independent monitor pops each entry
// shortly after and compares all four outputs.
// ----------------------------------------------------------------------------
module tb_time_parameters;
    import time_params_pkg::*;

    localparam int W = 4;

    logic clk    = 1'b0;
    logic rst    = 1'b1;
    bit   clk_en = 1'b0;

    // Edges land on multiples of 10; the monitor samples on odd times.
    always #10 if (clk_en) clk = ~clk;

    time_parameters_if #(.WIDTH(W)) bus ();

    logic [W-1:0] t_arm, t_drv, t_pas, t_alm;

    time_parameters dut (
        .clk               (clk),
        .rst               (rst),
        .cfg               (bus),
        .T_ARM_DELAY       (t_arm),
        .T_DRIVER_DELAY    (t_drv),
        .T_PASSENGER_DELAY (t_pas),
        .T_ALARM_ON        (t_alm)
    );

    typedef struct {
        string        name;
        logic [W-1:0] arm;
        logic [W-1:0] drv;
        logic [W-1:0] pas;
        logic [W-1:0] alm;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model of the four registers
    logic [W-1:0] m_arm, m_drv, m_pas, m_alm;

    function automatic void model_reset();
        m_arm = 4'd6;
        m_drv = 4'd8;
        m_pas = 4'd15;
        m_alm = 4'd10;
    endfunction

    function automatic void model_write(param_sel_e sel, logic [W-1:0] val);
`ifdef TP_ZERO_REJECT_EN
        if (val == '0) return;
`endif
        case (sel)
            SEL_ARM:       m_arm = val;
            SEL_DRIVER:    m_drv = val;
            SEL_PASSENGER: m_pas = val;
            default:       m_alm = val;
        endcase
    endfunction

    task automatic push(input string nm);
        exp_t e;
        e.name = nm;
        e.arm  = m_arm;
        e.drv  = m_drv;
        e.pas  = m_pas;
        e.alm  = m_alm;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string nm, input string fld,
                       input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s.%s actual=%0d required=%0d", nm, fld, act, req);
        end
    endtask

    // Monitor: compares every queued snapshot against the live outputs.
    initial begin
        exp_t e;
        #1;
        forever begin
            while (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk(e.name, "arm", t_arm, e.arm);
                chk(e.name, "drv", t_drv, e.drv);
                chk(e.name, "pas", t_pas, e.pas);
                chk(e.name, "alm", t_alm, e.alm);
                $display("t=%0t %-14s arm=%0d drv=%0d pas=%0d alm=%0d",
                         $time, e.name, t_arm, t_drv, t_pas, t_alm);
            end
            #2;
        end
    end

    // Single-cycle write: drive at negedge, model + expect after posedge.
    task automatic write(input param_sel_e sel, input logic [W-1:0] val,
                         input string nm);
        @(negedge clk);
        bus.param_select = sel;
        bus.time_value   = val;
        bus.reprogram    = 1'b1;
        @(posedge clk);
        model_write(sel, val);
        push(nm);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.reprogram = 1'b0;
    endtask

    initial begin
        model_reset();
        bus.param_select = SEL_ARM;
        bus.time_value   = 4'd1;
        bus.reprogram    = 1'b1;

        // 1. Asynchronous reset with the clock stopped
        #4 rst = 1'b0;
        #2 push("reset_noclk");
        #2 clk_en = 1'b1;
        // Reset held through clock edges with a write request present
        repeat (2) @(posedge clk);
        push("reset_clk");

        // Release reset with a write on the same edge
        @(negedge clk);
        bus.param_select = SEL_PASSENGER;
        bus.time_value   = 4'd12;
        bus.reprogram    = 1'b1;
        #4 rst = 1'b1;
        @(posedge clk);
        model_write(SEL_PASSENGER, 4'd12);
        push("release_wr");

        // 2./3. Single writes
        write(SEL_PASSENGER, 4'd5, "wr_pass5");
        write(SEL_ALARM,     4'd3, "wr_alarm3");
        idle();

        // 4. Strobe low: select/value toggled, nothing changes
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.reprogram    = 1'b0;
            bus.param_select = param_sel_e'(2'(i % 4));
            bus.time_value   = 4'(15 - i);
            @(posedge clk);
            push("no_strobe");
        end

        // 5. Strobe held: last value wins
        write(SEL_ARM, 4'd1, "hold_arm1");
        write(SEL_ARM, 4'd2, "hold_arm2");
        idle();

        // 6. Zero write to driver
        write(SEL_DRIVER, 4'd0, "wr_drv0");
        idle();

        // Select changes while strobe stays high; full-scale value
        write(SEL_DRIVER, 4'd15, "hold_drv15");
        write(SEL_ALARM,  4'd7,  "hold_alm7");
        idle();

        // Reset pulse between edges with a write pending: defaults win
        @(negedge clk);
        bus.param_select = SEL_PASSENGER;
        bus.time_value   = 4'd1;
        bus.reprogram    = 1'b1;
        #4 rst = 1'b0;
        model_reset();
        push("rst_pulse");
        #4;
        rst           = 1'b1;
        bus.reprogram = 1'b0;
        @(posedge clk);
        push("after_pulse");

        write(SEL_ARM, 4'd15, "wr_arm15");
        idle();
        @(posedge clk);
        push("final");

        // Let the monitor drain, bounded
        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        #4;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout actual=expired required=done");
        $fatal(1, "timeout");
    end

endmodule
